// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte bus between uart_rx and its downstream consumer
//
// Purpose: carries each recovered byte, its one-cycle strobe, the per-frame
// error flags and the receiver busy indication.
// Signals:
//   rx_data    [7:0] last received byte
//   rx_valid         one-cycle strobe, new rx_data and error flags
//   parity_err       parity mismatch for the frame in rx_data
//   frame_err        a stop bit was sampled low for the frame in rx_data
//   rx_busy          receiver is inside a frame
// Modports: master = receiver side (drives), slave = consumer side.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (output rx_data, rx_valid, parity_err, frame_err, rx_busy);
  modport slave  (input  rx_data, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8 data bits, optional parity, 1 or 2 stop bits
//
// Purpose: recovers 8-bit frames from an asynchronous serial line sampled at
// CLKS_PER_BIT clocks per bit, sampling each bit at its centre.
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   rx         serial line, asynchronous to clk, idles high
//   stop_bits  2 = two stop bits, anything else = one
//   parity     00 none, 01 even, 10 odd, 11 none
//   rx_bus     uart_rx_if.master: rx_data, rx_valid, parity_err, frame_err, rx_busy
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] stop_bits,
  input  logic [1:0] parity,
  uart_rx_if.master  rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;

  state_t state, state_next;

  logic          rx_meta, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_en, par_odd, two_stop;
  logic          par_err_q, frm_err_q;
  logic [7:0]    data_q;
  logic          valid_q, parity_err_q, frame_err_q;

  logic start_det;
  logic bit_sample;
  logic frame_done;

  // Edge detect needs rx_d=1, so a line stuck low (break) cannot retrigger.
  assign start_det = (state == IDLE) && rx_d && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bit_sample = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (start_det) state_next = START;
      START:  if (cnt == CNT_HALF) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        bit_sample = (cnt == CNT_LAST);
        if (bit_sample && bit_idx == 3'd7) state_next = par_en ? PARITY : STOP;
      end
      PARITY: begin
        bit_sample = (cnt == CNT_LAST);
        if (bit_sample) state_next = STOP;
      end
      STOP: begin
        bit_sample = (cnt == CNT_LAST);
        if (bit_sample) begin
          state_next = two_stop ? STOP2 : IDLE;
          frame_done = !two_stop;
        end
      end
      STOP2: begin
        bit_sample = (cnt == CNT_LAST);
        if (bit_sample) begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      par_en       <= 1'b0;
      par_odd      <= 1'b0;
      two_stop     <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          // Frame format is frozen at detection; later input changes are ignored.
          if (start_det) begin
            bit_idx   <= 3'd0;
            par_en    <= (parity == 2'b01) || (parity == 2'b10);
            par_odd   <= (parity == 2'b10);
            two_stop  <= (stop_bits == 2'd2);
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end
        end
        START:   cnt <= (cnt == CNT_HALF) ? '0 : cnt + CW'(1);
        default: cnt <= bit_sample ? '0 : cnt + CW'(1);
      endcase

      if (state == DATA && bit_sample) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == PARITY && bit_sample && (rx_s != (^shift ^ par_odd)))
        par_err_q <= 1'b1;

      if ((state == STOP || state == STOP2) && bit_sample && !rx_s)
        frm_err_q <= 1'b1;

      // Final stop sample folds directly into the registered flag.
      if (frame_done) begin
        data_q       <= shift;
        parity_err_q <= par_err_q;
        frame_err_q  <= frm_err_q | !rx_s;
        valid_q      <= 1'b1;
      end
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.parity_err = parity_err_q;
  assign rx_bus.frame_err  = frame_err_q;
  assign rx_bus.rx_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking randomized testbench for uart_rx
module tb_uart_rx;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int      CPB    = 16;
  localparam int      HALF   = CPB / 2;
  localparam realtime BIT_NS = 160.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] stop_bits = 2'd1;
  logic [1:0] parity = 2'b00;

  uart_rx_if rx_bus();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .stop_bits (stop_bits),
    .parity    (parity),
    .rx_bus    (rx_bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         valid_cnt = 0;
  int         last_valid_cyc = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  logic [7:0] last_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {frame_err, parity_err, data} from what was put on the line.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] par,
                                       input logic [1:0] sb, input logic pbit,
                                       input logic [1:0] stops);
    int   ones;
    logic pe, fe;
    ones = $countones(d);
    pe = 1'b0;
    if (par == 2'b01)      pe = (pbit != ((ones % 2) == 1));
    else if (par == 2'b10) pe = (pbit != ((ones % 2) == 0));
    fe = !stops[0] || ((sb == 2'd2) && !stops[1]);
    return {fe, pe, d};
  endfunction

  function automatic logic good_pbit(input logic [7:0] d, input logic [1:0] par);
    return ($countones(d) % 2 == 1) ^ (par == 2'b10);
  endfunction

  task automatic send(input logic [7:0] d, input logic [1:0] par, input logic [1:0] sb,
                      input logic pbit, input logic [1:0] stops, input realtime bit_t);
    exp_q.push_back(model(d, par, sb, pbit, stops));
    last_data = d;
    parity    = par;
    stop_bits = sb;
    rx = 1'b0;
    #(bit_t);
    parity    = 2'($urandom);
    stop_bits = 2'($urandom);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_t);
    end
    if (par == 2'b01 || par == 2'b10) begin
      rx = pbit;
      #(bit_t);
    end
    rx = stops[0];
    #(bit_t);
    if (sb == 2'd2) begin
      rx = stops[1];
      #(bit_t);
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"},  rx_bus.rx_data, 0);
    check({tag, "_valid"}, rx_bus.rx_valid, 0);
    check({tag, "_perr"},  rx_bus.parity_err, 0);
    check({tag, "_ferr"},  rx_bus.frame_err, 0);
    check({tag, "_busy"},  rx_bus.rx_busy, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && rx_bus.rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("rx_data", rx_bus.rx_data, mon_exp[7:0]);
        check("parity_err", rx_bus.parity_err, mon_exp[8]);
        check("frame_err", rx_bus.frame_err, mon_exp[9]);
      end
      check("busy_at_valid", rx_bus.rx_busy, 0);
    end
  end

  int         t0, v0, busy_cnt, skew;
  realtime    bt;
  logic [7:0] d;
  logic [1:0] par, sb, stops;
  logic       pbit;

  initial begin
    idle(3);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    // Exact-rate 0xA5: one strobe at D+HALF+9*CPB+1, D being two clocks after the line falls.
    @(posedge clk); #1;
    t0 = cyc;
    v0 = valid_cnt;
    send(8'hA5, 2'b00, 2'd1, 1'b0, 2'b11, BIT_NS);
    idle(20);
    check("a5_pulses", valid_cnt - v0, 1);
    check("a5_latency", last_valid_cyc - t0, HALF + 9 * CPB + 3);

    send(8'h07, 2'b01, 2'd1, 1'b1, 2'b11, BIT_NS); idle(20);
    send(8'h07, 2'b01, 2'd1, 1'b0, 2'b11, BIT_NS); idle(20);
    send(8'h07, 2'b10, 2'd1, 1'b0, 2'b11, BIT_NS); idle(20);
    send(8'h3C, 2'b00, 2'd1, 1'b0, 2'b10, BIT_NS); idle(20);

    // Break: one strobe of 0x00 with frame error, no retrigger while low.
    v0 = valid_cnt;
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    last_data = 8'h00;
    parity    = 2'b00;
    stop_bits = 2'd1;
    rx = 1'b0;
    #(BIT_NS * 30);
    check("break_strobes", valid_cnt - v0, 1);
    rx = 1'b1;
    #(BIT_NS * 3);
    check("break_after_high", valid_cnt - v0, 1);

    // Glitch of 3 clocks: busy for HALF cycles, no strobe, data held.
    send(8'h5A, 2'b00, 2'd1, 1'b0, 2'b11, BIT_NS); idle(20);
    v0 = valid_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (rx_bus.rx_busy) busy_cnt++;
    end
    check("glitch_busy_cycles", busy_cnt, HALF);
    check("glitch_no_strobe", valid_cnt - v0, 0);
    check("glitch_data_held", rx_bus.rx_data, last_data);

    // Two stop bits back-to-back with TX 2% fast; second frame has STOP2 low.
    v0 = valid_cnt;
    send(8'h55, 2'b00, 2'd2, 1'b0, 2'b11, BIT_NS * 0.98);
    send(8'hAA, 2'b00, 2'd2, 1'b0, 2'b01, BIT_NS * 0.98);
    idle(30);
    check("two_stop_strobes", valid_cnt - v0, 2);

    // Reset during DATA of 0xFF, then a clean 0x81.
    v0 = valid_cnt;
    parity    = 2'b00;
    stop_bits = 2'd1;
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(BIT_NS * 3);
    @(posedge clk); #1;
    rst = 1'b1;
    check_reset_outputs("midreset");
    idle(3);
    rst = 1'b0;
    #(BIT_NS * 12);
    check("abort_no_strobe", valid_cnt - v0, 0);
    send(8'h81, 2'b00, 2'd1, 1'b0, 2'b11, BIT_NS);
    idle(20);
    check("after_reset_strobe", valid_cnt - v0, 1);

    // Randomized frames: format, data, corrupted parity/stop bits, rate skew, phase.
    for (int i = 0; i < 24; i++) begin
      d     = 8'($urandom);
      par   = 2'($urandom);
      sb    = 2'($urandom);
      pbit  = good_pbit(d, par) ^ ($urandom_range(0, 3) == 0);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      skew  = int'($urandom_range(0, 4)) - 2;
      bt    = BIT_NS * (1.0 + skew / 100.0);
      #($urandom_range(0, 9));
      send(d, par, sb, pbit, stops, bt);
      #(bt * $urandom_range(1, 3));
    end

    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    idle(5);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers 8-bit frames from the serial line driven by the UART transmitter. It oversamples the line at CLKS_PER_BIT clocks per bit and supports optional even or odd parity and 1 or 2 stop bits. Each received byte is presented with a one-cycle valid strobe and per-frame error flags to the downstream consumer (host FIFO / register file).

## Interface
- CLKS_PER_BIT, default 16: clocks per serial bit. Legal values are ≥4. HALF = floor(CLKS_PER_BIT/2).
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  serial line. Asynchronous to clk; idles high.
- stop_bits  in  2  2 = two stop bits; any other value = one stop bit
- parity  in  2  2'b00 none, 2'b01 even, 2'b10 odd, 2'b11 treated as none
- rx_data  out  8  last received byte, LSB first on the line
- rx_valid  out  1  one-cycle strobe: new rx_data and error flags
- parity_err  out  1  parity mismatch for the frame in rx_data
- frame_err  out  1  a stop bit was sampled low for the frame in rx_data
- rx_busy  out  1  high whenever the state is not IDLE

## Operation
- Synchronizer: rx passes through 2 flops to give rx_s. A third flop gives rx_d, the previous rx_s. All three reset to 1.
- Start detect: only in IDLE, when rx_d=1 and rx_s=0. On detection, stop_bits and parity are latched for the whole frame; a change mid-frame has no effect.
- States: IDLE, START, DATA, PARITY, STOP, STOP2.
- START: baud counter cnt cleared on detection, then increments. At cnt==HALF-1, rx_s is sampled:
  - 1 (false start / glitch): go to IDLE; no strobe, outputs unchanged.
  - 0: cnt cleared, go to DATA.
- DATA: sample rx_s when cnt==CLKS_PER_BIT-1, then clear cnt. The 8 samples are shifted in LSB first. After bit 7, go to PARITY if parity is enabled, else to STOP.
- PARITY: one sample. Expected bit = ^data for even, ~^data for odd. Mismatch sets the internal parity error. Then go to STOP.
- STOP: one sample; 0 sets the internal frame error.
  - stop_bits==2: go to STOP2, which takes one more sample; 0 there also sets frame error.
  - Otherwise the frame completes.
- Frame completion:
  - Return to IDLE in the cycle after the final stop sample point, without waiting out the rest of the stop bit.
  - Outputs are registered: rx_data, parity_err and frame_err update and rx_valid=1 in the same cycle.
  - rx_data and the error flags hold until the next completed frame.
- Break (line held low): the frame completes with rx_data=0x00 and frame_err=1. No new start is detected until rx_s has returned high, because the edge detect requires rx_d=1.
- No backpressure: a new frame overwrites rx_data. The consumer must take the data on rx_valid.
- Reset, including mid-frame: abort to IDLE with cnt=0. rx_data=0x00; rx_valid, parity_err, frame_err and rx_busy are 0. Synchronizer flops are 1, so a line that is low at reset release does not trigger a start.

## Timing
- Line-to-detect latency: 2 clocks. Detection occurs in cycle D, the first cycle with rx_s=0 and rx_d=1.
- Sample points:
  - Start bit: D+HALF.
  - k-th subsequent bit (k=1..N): D+HALF+k·CLKS_PER_BIT, where N = 8 + (parity enabled) + (1 or 2 stop bits).
- rx_valid is high in exactly one cycle: D+HALF+N·CLKS_PER_BIT+1. rx_busy falls in that same cycle.
- rx_busy rises in cycle D+1 and stays high through the final sample cycle.
- Earliest next detection: the cycle rx_valid is high, if rx_s=0 and rx_d=1 then. This tolerates a TX clock up to ~HALF/(N·CLKS_PER_BIT) faster than the RX clock.

## Test plan
- 0xA5, no parity, 1 stop, CLKS_PER_BIT=16, bits at exact rate -> exactly one rx_valid pulse, at D+8+9·16+1; rx_data=0xA5; parity_err=0; frame_err=0.
- 0x07, even parity, parity bit 1 (correct) -> rx_data=0x07, parity_err=0. Same frame with parity bit 0 -> rx_data=0x07, parity_err=1. Odd parity with bit 0 -> parity_err=0.
- 0x3C, 1 stop, stop bit driven low -> rx_valid with rx_data=0x3C and frame_err=1. Continuous low line -> one strobe with 0x00 and frame_err=1, then no further strobes until the line goes high and then low again.
- rx low for 3 clocks then high (glitch) -> rx_busy high for HALF cycles, then IDLE; no rx_valid; rx_data unchanged.
- Two stop bits, back-to-back frames 0x55 then 0xAA, second STOP2 low; TX clock 2% fast -> two strobes, 0x55 with frame_err=0, then 0xAA with frame_err=1.
- rst asserted during DATA of 0xFF, released with line high, then 0x81 sent -> all outputs 0 during reset; no strobe for the aborted frame; next strobe carries rx_data=0x81 with no errors.
